fsk_word_receiver: RTL and testbench
====================================

# fsk_word_receiver

Receive-side FSK front end. It samples the raw FSK line on the system clock and counts line transitions in each bit window delimited by the bit-rate strobe. From that count it decides mark or space, then assembles consecutive bits MSB-first into 14-bit Hamming code words. It sits between the FSK line and the Hamming decoder and replaces the plain demodulator with a carrier-aware, framed receiver.

## Interface
Parameters:
- WORD_BITS, 14, bits per received code word.
- EDGE_THRESH, 3, minimum rising edges per window to decide bit 1 (mark); fewer but nonzero decides 0 (space).
- CNT_W, 6, edge-counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- bit_tick  input  1  one-cycle strobe marking the end of each bit window (clk-synchronous).
- fsk_in  input  1  raw FSK line, asynchronous to clk.
- bit_out  output  1  last decided bit.
- bit_valid  output  1  one-cycle pulse: bit_out was updated.
- word_out  output  WORD_BITS  last complete word, MSB = first received bit.
- word_valid  output  1  one-cycle pulse: word_out was updated.
- carrier_lost  output  1  one-cycle pulse: the carrier dropped mid-word and the partial word was discarded.

## Operation
- fsk_in passes through a 2-FF synchronizer, then a rising-edge detector (edge_pulse).
- edge_cnt increments on edge_pulse and saturates at max.
- On a bit_tick cycle, the window count is n = edge_cnt + edge_pulse (saturating). The edge on the tick cycle belongs to the closing window. edge_cnt then loads 0.
- Decision: bit = (n >= EDGE_THRESH).
- States:
  - ARM (reset state): the first bit_tick only aligns the window. Go to IDLE; no outputs.
  - IDLE: on bit_tick with n = 0, stay. With n > 0, shift the decided bit into bit 0 of the shift register, set bit_cnt = 1, pulse bit_valid, and go to RECV.
  - RECV: on bit_tick with n > 0, shift in the bit, bit_cnt++, pulse bit_valid. When bit_cnt reaches WORD_BITS:
    - load word_out from the shift register including the new bit;
    - pulse word_valid;
    - set bit_cnt = 0 and stay in RECV.
  - RECV, bit_tick with n = 0: pulse carrier_lost, set bit_cnt = 0, clear the shift register, go to IDLE. word_out is unchanged; no bit_valid.
- Back-to-back words need no gap. The first bit of the next word may arrive on the tick following word completion.
- bit_tick is ignored except at the window boundary. A bit_tick on consecutive cycles is legal; each tick closes a window of its own length.

## Timing
- Reset values: bit_out = 0, bit_valid = 0, word_out = 0, word_valid = 0, carrier_lost = 0. State is ARM, edge_cnt = 0, bit_cnt = 0, shift register = 0.
- Pin-to-edge latency: a fsk_in rise is counted 3 clk after it arrives (2 synchronizer stages + edge register).
- bit_out and bit_valid are registered and update in the cycle after the bit_tick cycle.
- word_valid and word_out update in the same cycle as the bit_valid for the final bit.
- carrier_lost is asserted in the cycle after the offending bit_tick.
- word_valid and carrier_lost are never asserted together.
- Reset asserted mid-word: outputs clear immediately (asynchronously). The partial word is lost, and reception restarts from ARM.

## Test plan
- Reset, then bit_tick every 32 clk with fsk_in toggling every 4 clk (4 rises/window) -> first tick: no pulse; second tick: bit_valid with bit_out = 1; word_valid after 14 further ticks, word_out = 14'h3FFF.
- Pattern 14'b10110011100101: mark = 4 rises/window, space = 2 rises/window -> word_out = 14'h2CE5 with one word_valid pulse; bit_valid fires 14 times.
- Window with exactly 3 rises, the third rise synchronized onto the tick cycle -> bit_out = 1; the same pattern with the rise one cycle after the tick -> bit_out = 0, and the next window's count starts at 1.
- fsk_in held low for one window after 6 bits of a word -> carrier_lost pulse, no word_valid, word_out unchanged. The next 14 nonzero windows produce a fresh word.
- Two words sent back-to-back (14'h1234 & 14'h3FFF, then 14'h0ABC) -> word_valid pulses exactly 14 ticks apart with the correct values.
- Drive fsk_in at 1/2 clk rate for a window longer than 2^CNT_W edges -> count saturates at 63, bit_out = 1, no wrap. Assert reset mid-word -> all outputs read 0 within the same cycle, and the state returns to ARM.

Source files
------------

// File: rtl/fsk_word_receiver_if.sv
// Line-side and word-side signals of the FSK word receiver.
// The receiver takes the slave view; its driver takes the master view.
interface fsk_word_receiver_if #(
    parameter int WORD_BITS = 14
);
    logic                 bit_tick;
    logic                 fsk_in;
    logic                 bit_out;
    logic                 bit_valid;
    logic [WORD_BITS-1:0] word_out;
    logic                 word_valid;
    logic                 carrier_lost;

    modport master (
        output bit_tick,
        output fsk_in,
        input  bit_out,
        input  bit_valid,
        input  word_out,
        input  word_valid,
        input  carrier_lost
    );

    modport slave (
        input  bit_tick,
        input  fsk_in,
        output bit_out,
        output bit_valid,
        output word_out,
        output word_valid,
        output carrier_lost
    );
endinterface

// File: rtl/fsk_word_receiver.sv
// FSK receive front end: counts synchronized line rises per bit window,
// decides mark/space and frames bits MSB-first into code words.
module fsk_word_receiver #(
    parameter int WORD_BITS   = 14,
    parameter int EDGE_THRESH = 3,
    parameter int CNT_W       = 6
) (
    input logic                  clk,
    input logic                  reset,
    fsk_word_receiver_if.slave   bus
);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        RECV
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 edge_ref_q, edge_ref_d;
    logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic                 bit_out_q, bit_out_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 word_valid_q, word_valid_d;
    logic                 carrier_lost_q, carrier_lost_d;

    logic                 edge_pulse;
    logic [CNT_W-1:0]     win_cnt;
    logic                 bit_dec;
    logic                 has_edges;

    always_comb begin
        sync1_d    = bus.fsk_in;
        sync2_d    = sync1_q;
        edge_ref_d = sync2_q;
        edge_pulse = sync2_q & ~edge_ref_q;

        // An edge on the tick cycle still belongs to the closing window.
        win_cnt = edge_cnt_q;
        if (edge_pulse && edge_cnt_q != CNT_MAX) begin
            win_cnt = edge_cnt_q + 1'b1;
        end
        edge_cnt_d = bus.bit_tick ? '0 : win_cnt;
        bit_dec    = win_cnt >= CNT_W'(EDGE_THRESH);
        has_edges  = win_cnt != '0;

        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        word_d         = word_q;
        bit_out_d      = bit_out_q;
        bit_valid_d    = 1'b0;
        word_valid_d   = 1'b0;
        carrier_lost_d = 1'b0;

        if (bus.bit_tick) begin
            unique case (state_q)
                ARM: begin
                    state_d = IDLE;
                end
                IDLE: begin
                    if (has_edges) begin
                        shift_d     = {shift_q[WORD_BITS-2:0], bit_dec};
                        bit_cnt_d   = BW'(1);
                        bit_out_d   = bit_dec;
                        bit_valid_d = 1'b1;
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (has_edges) begin
                        shift_d     = {shift_q[WORD_BITS-2:0], bit_dec};
                        bit_out_d   = bit_dec;
                        bit_valid_d = 1'b1;
                        if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
                            word_d       = shift_d;
                            word_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        // Silent window mid-word: drop the partial word.
                        carrier_lost_d = 1'b1;
                        bit_cnt_d      = '0;
                        shift_d        = '0;
                        state_d        = IDLE;
                    end
                end
                default: begin
                    state_d = ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ARM;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            edge_ref_q     <= 1'b0;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            word_q         <= '0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            word_valid_q   <= 1'b0;
            carrier_lost_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            edge_ref_q     <= edge_ref_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            word_q         <= word_d;
            bit_out_q      <= bit_out_d;
            bit_valid_q    <= bit_valid_d;
            word_valid_q   <= word_valid_d;
            carrier_lost_q <= carrier_lost_d;
        end
    end

    assign bus.bit_out      = bit_out_q;
    assign bus.bit_valid    = bit_valid_q;
    assign bus.word_out     = word_q;
    assign bus.word_valid   = word_valid_q;
    assign bus.carrier_lost = carrier_lost_q;
endmodule

// File: tb/tb_fsk_word_receiver.sv
// Bench for fsk_word_receiver: directed scenarios plus random line
// activity, checked against a window-count reference model.
module tb_fsk_word_receiver;
    localparam int WB  = 14;
    localparam int SAT = 63;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fsk_word_receiver_if #(.WORD_BITS(WB)) bus ();

    fsk_word_receiver #(
        .WORD_BITS  (WB),
        .EDGE_THRESH(3),
        .CNT_W      (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: each line rise is stamped with the clock edge on
    // which the receiver can first see it.
    int   cyc = 0;
    logic fsk_prev = 1'b0;
    int   rise_q[$];
    bit   m_armed;
    bit   m_active;
    int   m_nb;
    int   m_bits;
    logic m_bit;
    logic [WB-1:0] m_word;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_armed  = 1'b0;
        m_active = 1'b0;
        m_nb     = 0;
        m_bits   = 0;
        m_bit    = 1'b0;
        m_word   = '0;
        rise_q.delete();
    endtask

    task automatic model_tick();
        int   n;
        logic bv;
        logic wv;
        logic cl;
        n  = 0;
        bv = 1'b0;
        wv = 1'b0;
        cl = 1'b0;
        while (rise_q.size() > 0 && rise_q[0] <= cyc) begin
            void'(rise_q.pop_front());
            n++;
        end
        if (n > SAT) n = SAT;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else if (n == 0) begin
            cl       = m_active;
            m_active = 1'b0;
            m_nb     = 0;
            m_bits   = 0;
        end else begin
            m_bit    = (n >= 3);
            m_bits   = (m_bits << 1) | int'(m_bit);
            m_nb++;
            m_active = 1'b1;
            bv       = 1'b1;
            if (m_nb == WB) begin
                m_word = m_bits[WB-1:0];
                wv     = 1'b1;
                m_nb   = 0;
            end
        end
        check("bit_valid", 32'(bus.bit_valid), 32'(bv));
        check("word_valid", 32'(bus.word_valid), 32'(wv));
        check("carrier_lost", 32'(bus.carrier_lost), 32'(cl));
        check("bit_out", 32'(bus.bit_out), 32'(m_bit));
        check("word_out", 32'(bus.word_out), 32'(m_word));
    endtask

    task automatic step(input logic f, input logic t);
        @(negedge clk);
        if (f && !fsk_prev) rise_q.push_back(cyc + 2);
        fsk_prev     = f;
        bus.fsk_in   = f;
        bus.bit_tick = t;
        @(posedge clk);
        #1;
        if (t) begin
            model_tick();
        end else begin
            check("no_pulse",
                  32'({bus.bit_valid, bus.word_valid, bus.carrier_lost}),
                  32'(0));
        end
        cyc++;
    endtask

    task automatic window(input int len, input int r);
        for (int i = 0; i < len; i++) begin
            step((i < 2 * r) && (i % 2 == 0), i == len - 1);
        end
    endtask

    task automatic window_third(input int off);
        for (int i = 0; i < 32; i++) begin
            step(i == 0 || i == 2 || i == off, i == 31);
        end
    endtask

    task automatic send_word(input logic [WB-1:0] w);
        for (int b = WB - 1; b >= 0; b--) begin
            window(32, w[b] ? 4 : 2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.fsk_in   = 1'b0;
        bus.bit_tick = 1'b0;
        fsk_prev     = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_bit_out", 32'(bus.bit_out), 32'(0));
        check("rst_bit_valid", 32'(bus.bit_valid), 32'(0));
        check("rst_word_out", 32'(bus.word_out), 32'(0));
        check("rst_word_valid", 32'(bus.word_valid), 32'(0));
        check("rst_carrier", 32'(bus.carrier_lost), 32'(0));
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [WB-1:0] w;
        int len;
        int dens;
        bit quiet;
        bus.fsk_in   = 1'b0;
        bus.bit_tick = 1'b0;
        model_clear();
        #3;
        do_reset();

        // Alignment tick, then fourteen marks.
        window(32, 4);
        check("arm_no_bit", 32'(bus.bit_valid), 32'(0));
        for (int i = 0; i < WB; i++) window(32, 4);
        check("all_marks", 32'(bus.word_out), 32'h3FFF);

        send_word(14'b10110011100101);
        check("pattern_word", 32'(bus.word_out), 32'h2CE5);

        // Third rise landing on the tick vs one cycle later.
        window_third(29);
        check("edge_on_tick", 32'(bus.bit_out), 32'(1));
        window_third(30);
        check("edge_after_tick", 32'(bus.bit_out), 32'(0));
        window(32, 2);
        check("carry_edge", 32'(bus.bit_out), 32'(1));
        for (int i = 0; i < 3; i++) window(32, 4);
        window(32, 0);
        check("lost_pulse", 32'(bus.carrier_lost), 32'(1));
        check("lost_word_kept", 32'(bus.word_out), 32'h2CE5);
        w = WB'($urandom);
        send_word(w);
        check("fresh_word", 32'(bus.word_out), 32'(w));

        send_word(14'h1234);
        check("b2b_w1", 32'(bus.word_out), 32'h1234);
        send_word(14'h3FFF);
        check("b2b_w2", 32'(bus.word_out), 32'h3FFF);
        send_word(14'h0ABC);
        check("b2b_w3", 32'(bus.word_out), 32'h0ABC);

        // 65 rises in one window: saturates rather than wrapping to 1.
        for (int i = 0; i < 131; i++) begin
            step((i % 2 == 0) && (i <= 128), i == 130);
        end
        check("sat_mark", 32'(bus.bit_out), 32'(1));
        window(32, 4);
        window(32, 2);
        do_reset();

        for (int k = 0; k < 200; k++) begin
            len   = $urandom_range(1, 40);
            quiet = ($urandom_range(0, 7) == 0);
            dens  = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                step(!quiet && ($urandom_range(0, dens) == 0),
                     i == len - 1);
            end
        end
        do_reset();
        window(32, 3);
        for (int k = 0; k < 3; k++) begin
            w = WB'($urandom);
            send_word(w);
            check("rand_word", 32'(bus.word_out), 32'(w));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
